// File: rtl/img_readback_dma.sv
// img_readback_dma: reads processed rows back from the image buffer and streams them out pixel by pixel.
// Build macro READBACK_PREFETCH_EN overlaps the next row fetch with streaming to remove row-boundary bubbles.
module img_readback_dma #(
  parameter int         IMG_W     = 256,
  parameter int         IMG_H     = 256,
  parameter int         PIX_W     = 8,
  parameter logic [8:0] BASE_ADDR = 9'h100,
  localparam int        CW        = $clog2(IMG_W),
  localparam int        RW        = $clog2(IMG_H)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   rd_en,
  output logic [8:0]             rd_addr,
  input  logic [IMG_W*PIX_W-1:0] rdata,
  output logic [PIX_W-1:0]       pix_data,
  output logic                   pix_vld,
  input  logic                   pix_rdy,
  output logic [RW-1:0]          pix_row,
  output logic [CW-1:0]          pix_col,
  output logic                   pix_last,
  output logic                   rdy,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, DONE} state_t;

  state_t                 state, state_nxt;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col;
  logic [IMG_W*PIX_W-1:0] active;
  logic                   streaming, xfer, last_col, last_row, row_end, kill;

  assign streaming = (state == STREAM);
  assign xfer      = streaming & pix_rdy;
  assign last_col  = (col == CW'(IMG_W-1));
  assign last_row  = (row == RW'(IMG_H-1));
  assign row_end   = xfer & last_col & ~abort;
  assign kill      = abort & (state != IDLE);

`ifdef READBACK_PREFETCH_EN
  localparam state_t ROW_NEXT = STREAM;

  logic [IMG_W*PIX_W-1:0] shadow;
  logic                   pf_issued, pf_pend, pf_req;

  // One prefetch per row: issued on the first col-0 cycle, held off by pf_issued through stalls.
  assign pf_req  = streaming & (col == '0) & ~pf_issued & ~last_row;
  assign rd_en   = (state == FETCH) | pf_req;
  assign rd_addr = BASE_ADDR + 9'(row) + {8'd0, streaming};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      pf_issued <= 1'b0;
      pf_pend   <= 1'b0;
    end else if (kill) begin
      shadow    <= '0;
      pf_issued <= 1'b0;
      pf_pend   <= 1'b0;
    end else begin
      pf_pend <= pf_req;
      if (pf_pend) shadow <= rdata;
      if (pf_req)       pf_issued <= 1'b1;
      else if (row_end) pf_issued <= 1'b0;
    end
  end
`else
  localparam state_t ROW_NEXT = FETCH;

  assign rd_en   = (state == FETCH);
  assign rd_addr = BASE_ADDR + 9'(row);
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = STREAM;
      STREAM:  if (xfer && last_col) state_nxt = last_row ? DONE : ROW_NEXT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      active <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (state == WAIT && !abort) begin
        active <= rdata;
        col    <= '0;
      end
      if (xfer && !abort) begin
        if (last_col) begin
          col <= '0;
          if (!last_row) row <= row + 1'b1;
`ifdef READBACK_PREFETCH_EN
          active <= shadow;
`endif
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign pix_vld  = streaming;
  assign pix_data = streaming ? active[col*PIX_W +: PIX_W] : '0;
  assign pix_row  = row;
  assign pix_col  = col;
  assign pix_last = streaming & last_row & last_col;
  assign rdy      = (state == IDLE);
  assign done     = (state == DONE);

endmodule

// File: doc/img_readback_dma.md
# img_readback_dma

Result-readback engine for the image coprocessor. After the processing DMA has written filtered rows into the upper half of the image buffer (addresses 0x100–0x1FF), this block reads those rows back one row per buffer access. It serializes each row into a pixel stream with a valid/ready handshake, which the host processor or VGA path consumes. It is the read-side counterpart of the row-writing address calculator.

## Interface
Parameters:
- IMG_W, 256, pixels per row (power of two, ≥ 4)
- IMG_H, 256, rows per image
- PIX_W, 8, bits per pixel
- BASE_ADDR, 9'h100, buffer address of processed row 0

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin readback; sampled only in IDLE
- abort  in  1  synchronous cancel; return to IDLE, no done
- rd_en  out  1  image buffer read enable
- rd_addr  out  9  image buffer read address
- rdata  in  IMG_W*PIX_W  row data, valid the cycle after rd_en
- pix_data  out  PIX_W  current pixel
- pix_vld  out  1  pixel valid
- pix_rdy  in  1  downstream ready
- pix_row  out  log2(IMG_H)  row index of pix_data
- pix_col  out  log2(IMG_W)  column index of pix_data
- pix_last  out  1  final pixel of the image
- rdy  out  1  high in IDLE
- done  out  1  one-cycle pulse after the final pixel transfer

## Operation
- States: IDLE, FETCH, WAIT, STREAM, DONE.
- IDLE: rdy=1. start=1 -> FETCH; row=0.
- FETCH: rd_en=1, rd_addr=BASE_ADDR+row -> WAIT.
- WAIT: capture rdata into the active row register -> STREAM; col=0.
- STREAM: pix_vld=1; pix_data=active[col*PIX_W +: PIX_W], so col 0 is the LSBs.
  - Transfer = pix_vld & pix_rdy. On a transfer, col increments.
  - Transfer at col=IMG_W-1, row<IMG_H-1: row increments, col=0, next row begins.
  - Transfer at col=IMG_W-1, row=IMG_H-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- pix_last = STREAM & row=IMG_H-1 & col=IMG_W-1.
- Address arithmetic: 9-bit BASE_ADDR+row with no wrap; BASE_ADDR+IMG_H-1 ≤ 511 is required.
- abort in any non-IDLE state -> IDLE next cycle; pix_vld drops, done stays 0, and any in-flight read is discarded. abort in IDLE has no effect.
- start outside IDLE is ignored. Simultaneous start and abort in IDLE: start wins.
- Simultaneous abort and final transfer: abort wins, done stays 0.

## Timing
- Reset values:
  - state: IDLE
  - rdy: 1
  - done, rd_en, pix_vld, pix_last: 0
  - pix_data, pix_row, pix_col: 0
  - rd_addr: BASE_ADDR
- Start latency: start sampled at edge 0; rd_en high in cycle 1; rdata captured at edge 2; first pix_vld in cycle 3.
- Handshake: while pix_vld=1 and pix_rdy=0, pix_data, pix_row, pix_col and pix_last hold stable. pix_vld never drops without a transfer, except on abort.
- Throughput: one pixel per cycle when pix_rdy is held high.
- Row boundary without prefetch: 2 bubble cycles (FETCH, WAIT) with pix_vld=0.
- done is asserted the cycle after the final transfer. rdy returns the cycle after done.
- Reset mid-operation: all outputs immediately take their reset values; no done pulse.

## Configuration
- Macro READBACK_PREFETCH_EN.
- Defined:
  - A shadow row register is added.
  - In the first STREAM cycle of row r (col=0), rd_en is pulsed for row r+1 when r<IMG_H-1, and rdata is captured into the shadow register on the following edge.
  - On the final transfer of row r, shadow copies to active, and STREAM continues with no bubble.
  - rd_en pulses exactly once per row regardless of pix_rdy stalls.
  - abort discards the shadow register.
- Undefined: no shadow register, and every row boundary passes through FETCH and WAIT.

## Test plan
- Reset then idle: rdy=1, pix_vld=0, rd_addr=0x100. Then start with pix_rdy=1: rd_en in cycle 1 with addr 0x100, pix_vld in cycle 3, and col 0 equals rdata[7:0].
- Full image with pix_rdy=1: 65536 transfers in raster order and pixel values match the buffer model. pix_last appears only on (255,255), done is high exactly 1 cycle, rdy follows. Total cycles: 65536+2*256+2 without prefetch, 65536+2+2 with prefetch.
- Random pix_rdy backpressure (50%): no pixel is lost or duplicated, outputs are stable during stalls, and rd_en count is 256.
- abort asserted at row 3 col 100: pix_vld=0 the next cycle, IDLE, no done. A fresh start then restarts at rd_addr 0x100.
- rst_n pulsed low mid-row: all outputs immediately at reset values. start during STREAM is ignored and the row sequence is unchanged.
